// File: rtl/motor_pkg.sv
// Shared mode encodings, paddle bit order and mode-relationship helpers
// for the motor mode sequencer.
package motor_pkg;

   typedef enum logic [2:0] {
      MODE_STOP = 3'b000,
      MODE_R_1X = 3'b001,
      MODE_R_2X = 3'b010,
      MODE_L_1X = 3'b011,
      MODE_L_2X = 3'b100,
      MODE_FWD  = 3'b101,
      MODE_REV  = 3'b110
   } mode_t;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_BRAKE = 1'b1
   } state_t;

   // Bit positions of the paddles inside the 4-bit decode vector
   // {left_fwd, left_rev, right_fwd, right_rev}.
   localparam int unsigned BIT_LEFT_FWD  = 3;
   localparam int unsigned BIT_LEFT_REV  = 2;
   localparam int unsigned BIT_RIGHT_FWD = 1;
   localparam int unsigned BIT_RIGHT_REV = 0;

   function automatic logic is_right(input mode_t m);
      return (m == MODE_R_1X) || (m == MODE_R_2X);
   endfunction

   function automatic logic is_left(input mode_t m);
      return (m == MODE_L_1X) || (m == MODE_L_2X);
   endfunction

   // Modes that need a pass through STOP before switching between them.
   function automatic logic is_opposite(input mode_t a, input mode_t b);
      return ((a == MODE_FWD) && (b == MODE_REV)) ||
             ((a == MODE_REV) && (b == MODE_FWD)) ||
             (is_right(a) && is_left(b)) ||
             (is_left(a) && is_right(b));
   endfunction

   // 1X mode on the same side as m; STOP for modes without a side.
   function automatic mode_t same_side_1x(input mode_t m);
      if (is_left(m)) return MODE_L_1X;
      else if (is_right(m)) return MODE_R_1X;
      else return MODE_STOP;
   endfunction

endpackage

// File: rtl/clk_enable_div.sv
// Free-running divider producing a one-cycle enable strobe every DIV clocks.
module clk_enable_div #(
   parameter int unsigned DIV = 4
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam int unsigned W = $clog2(DIV);
   localparam logic [W-1:0] LAST = W'(DIV - 1);

   logic [W-1:0] cnt;

   // Count 0..DIV-1 and wrap; reset restarts the period from zero.
   always_ff @(posedge clk) begin
      if (reset) cnt <= '0;
      else if (cnt == LAST) cnt <= '0;
      else cnt <= cnt + W'(1);
   end

   // Reset masks the strobe so a tick never coincides with reset.
   assign tick = (cnt == LAST) && !reset;

endmodule

// File: rtl/motor_mode_sequencer.sv
// Paddle decode, tick-based debounce and RUN/BRAKE mode sequencer that
// ramps 2X modes through 1X and brakes through STOP on direction reversal.
module motor_mode_sequencer
   import motor_pkg::*;
#(
   parameter int unsigned CLK_DIV      = 20_000_000,
   parameter int unsigned STABLE_TICKS = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       left_fwd,
   input  logic       left_rev,
   input  logic       right_fwd,
   input  logic       right_rev,
   output logic [2:0] motor_mode,
   output logic       mode_changed,
   output logic       tick
);

   localparam logic [3:0] STABLE_MAX = 4'(STABLE_TICKS);

   logic [3:0] paddles;
   mode_t      decoded;
   mode_t      candidate, candidate_nxt;
   logic [3:0] stable_cnt, stable_cnt_nxt;
   mode_t      target;
   state_t     state, state_nxt;
   mode_t      mode_q, mode_nxt;
   logic       changed_nxt;

   function automatic mode_t decode(input logic [3:0] p);
      case (p)
         4'b0000:          decode = MODE_STOP;
         4'b1000, 4'b0001: decode = MODE_R_1X;
         4'b1001:          decode = MODE_R_2X;
         4'b0010, 4'b0100: decode = MODE_L_1X;
         4'b0110:          decode = MODE_L_2X;
         4'b1010:          decode = MODE_FWD;
         4'b0101:          decode = MODE_REV;
         default:          decode = MODE_STOP;
      endcase
   endfunction

   // A 2X target is reached via its same-side 1X unless already on that side.
   function automatic mode_t run_step(input mode_t tgt, input mode_t cur);
      if (((tgt == MODE_R_2X) || (tgt == MODE_L_2X)) &&
          (same_side_1x(cur) != same_side_1x(tgt)))
         run_step = same_side_1x(tgt);
      else
         run_step = tgt;
   endfunction

   clk_enable_div #(.DIV(CLK_DIV)) u_div (
      .clk   (clk),
      .reset (reset),
      .tick  (tick)
   );

   // Assemble the raw paddle vector and decode the requested mode.
   always_comb begin
      paddles = '0;
      paddles[BIT_LEFT_FWD]  = left_fwd;
      paddles[BIT_LEFT_REV]  = left_rev;
      paddles[BIT_RIGHT_FWD] = right_fwd;
      paddles[BIT_RIGHT_REV] = right_rev;
      decoded = decode(paddles);
   end

   // Debounce next-state: extend the run of equal samples or restart it.
   always_comb begin
      candidate_nxt  = candidate;
      stable_cnt_nxt = stable_cnt;
      if (decoded == candidate) begin
         if (stable_cnt != STABLE_MAX) stable_cnt_nxt = stable_cnt + 4'd1;
      end else begin
         candidate_nxt  = decoded;
         stable_cnt_nxt = 4'd1;
      end
   end

   // Debounce registers; target latches once a request has been stable long enough.
   always_ff @(posedge clk) begin
      if (reset) begin
         candidate  <= MODE_STOP;
         stable_cnt <= '0;
         target     <= MODE_STOP;
      end else if (tick) begin
         candidate  <= candidate_nxt;
         stable_cnt <= stable_cnt_nxt;
         if (stable_cnt_nxt == STABLE_MAX) target <= candidate_nxt;
      end
   end

   // Sequencer next-state: one step per tick toward the previously latched target.
   always_comb begin
      state_nxt   = state;
      mode_nxt    = mode_q;
      changed_nxt = 1'b0;
      if (tick) begin
         case (state)
            ST_RUN: begin
               if (is_opposite(target, mode_q)) begin
                  mode_nxt  = MODE_STOP;
                  state_nxt = ST_BRAKE;
               end else begin
                  mode_nxt = run_step(target, mode_q);
               end
            end
            ST_BRAKE: begin
               state_nxt = ST_RUN;
               mode_nxt  = run_step(target, mode_q);
            end
            default: state_nxt = ST_RUN;
         endcase
         changed_nxt = (mode_nxt != mode_q);
      end
   end

   // Sequencer state, commanded mode and change strobe registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ST_RUN;
         mode_q       <= MODE_STOP;
         mode_changed <= 1'b0;
      end else begin
         state        <= state_nxt;
         mode_q       <= mode_nxt;
         mode_changed <= changed_nxt;
      end
   end

   assign motor_mode = mode_q;

endmodule

// File: tb/tb_motor_mode_sequencer.sv
// Scenario bench for motor_mode_sequencer with CLK_DIV=4, STABLE_TICKS=2.
module tb_motor_mode_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       left_fwd, left_rev, right_fwd, right_rev;
   logic [2:0] motor_mode;
   logic       mode_changed;
   logic       tick;

   int vectors = 0;
   int miscompares = 0;
   int pulses = 0;

   logic [2:0] exp_mode_q[$];
   logic       exp_chg_q[$];

   motor_mode_sequencer #(.CLK_DIV(4), .STABLE_TICKS(2)) dut (
      .clk          (clk),
      .reset        (reset),
      .left_fwd     (left_fwd),
      .left_rev     (left_rev),
      .right_fwd    (right_fwd),
      .right_rev    (right_rev),
      .motor_mode   (motor_mode),
      .mode_changed (mode_changed),
      .tick         (tick)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (mode_changed === 1'b1) pulses <= pulses + 1;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1);
   end

   task automatic set_paddles(input logic [3:0] v);
      {left_fwd, left_rev, right_fwd, right_rev} = v;
   endtask

   // Counts cycles until tick is seen, then steps just past the consuming edge.
   task automatic measure_gap(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (tick !== 1'b1 && n < 20);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_tick();
      int n;
      measure_gap(n);
      if (n >= 20) begin
         vectors++;
         miscompares++;
         $display("FAIL tick_timeout: no tick in %0d cycles, required one within 4", n);
      end
   endtask

   task automatic push_exp(input logic [2:0] m, input logic c);
      exp_mode_q.push_back(m);
      exp_chg_q.push_back(c);
   endtask

   task automatic test_reset();
      int n;
      reset = 1'b1;
      set_paddles(4'b0000);
      repeat (3) @(posedge clk);
      @(negedge clk);
      vectors++;
      if (tick !== 1'b0) begin miscompares++; $display("FAIL rst_tick_held: tick=%b required 0", tick); end
      @(posedge clk);
      #1 reset = 1'b0;
      vectors++;
      if (motor_mode !== 3'b000) begin miscompares++; $display("FAIL rst_mode: motor_mode=%b required 000", motor_mode); end
      vectors++;
      if (mode_changed !== 1'b0) begin miscompares++; $display("FAIL rst_chg: mode_changed=%b required 0", mode_changed); end
      measure_gap(n);
      vectors++;
      if (n !== 4) begin miscompares++; $display("FAIL rst_first_tick: gap=%0d required 4", n); end
      measure_gap(n);
      vectors++;
      if (n !== 4) begin miscompares++; $display("FAIL tick_period: gap=%0d required 4", n); end
      vectors++;
      if (motor_mode !== 3'b000) begin miscompares++; $display("FAIL rst_idle_mode: motor_mode=%b required 000", motor_mode); end
   endtask

   task automatic test_fwd();
      int p0;
      logic [2:0] em;
      logic ec;
      p0 = pulses;
      set_paddles(4'b1010);
      push_exp(3'b000, 0); push_exp(3'b000, 0); push_exp(3'b101, 1); push_exp(3'b101, 0);
      for (int i = 0; i < 4; i++) begin
         wait_tick();
         em = exp_mode_q.pop_front();
         ec = exp_chg_q.pop_front();
         vectors++;
         if (motor_mode !== em) begin miscompares++; $display("FAIL fwd_mode[%0d]: motor_mode=%b required %b", i, motor_mode, em); end
         vectors++;
         if (mode_changed !== ec) begin miscompares++; $display("FAIL fwd_chg[%0d]: mode_changed=%b required %b", i, mode_changed, ec); end
      end
      vectors++;
      if (pulses - p0 !== 1) begin miscompares++; $display("FAIL fwd_pulses: count=%0d required 1", pulses - p0); end
   endtask

   task automatic test_reverse();
      int p0;
      logic [2:0] em;
      logic ec;
      p0 = pulses;
      set_paddles(4'b0101);
      push_exp(3'b101, 0); push_exp(3'b101, 0); push_exp(3'b000, 1);
      push_exp(3'b110, 1); push_exp(3'b110, 0);
      for (int i = 0; i < 5; i++) begin
         wait_tick();
         em = exp_mode_q.pop_front();
         ec = exp_chg_q.pop_front();
         vectors++;
         if (motor_mode !== em) begin miscompares++; $display("FAIL rev_mode[%0d]: motor_mode=%b required %b", i, motor_mode, em); end
         vectors++;
         if (mode_changed !== ec) begin miscompares++; $display("FAIL rev_chg[%0d]: mode_changed=%b required %b", i, mode_changed, ec); end
      end
      vectors++;
      if (pulses - p0 !== 2) begin miscompares++; $display("FAIL rev_pulses: count=%0d required 2", pulses - p0); end
   endtask

   task automatic test_ramp_right();
      logic [2:0] em;
      logic ec;
      set_paddles(4'b0000);
      push_exp(3'b110, 0); push_exp(3'b110, 0); push_exp(3'b000, 1); push_exp(3'b000, 0);
      push_exp(3'b000, 0); push_exp(3'b000, 0); push_exp(3'b001, 1); push_exp(3'b010, 1);
      push_exp(3'b010, 0);
      for (int i = 0; i < 9; i++) begin
         wait_tick();
         em = exp_mode_q.pop_front();
         ec = exp_chg_q.pop_front();
         vectors++;
         if (motor_mode !== em) begin miscompares++; $display("FAIL ramp_mode[%0d]: motor_mode=%b required %b", i, motor_mode, em); end
         vectors++;
         if (mode_changed !== ec) begin miscompares++; $display("FAIL ramp_chg[%0d]: mode_changed=%b required %b", i, mode_changed, ec); end
         if (i == 3) set_paddles(4'b1001);
      end
   endtask

   task automatic test_glitch();
      int p0;
      logic [2:0] em;
      logic ec;
      p0 = 0;
      set_paddles(4'b0000);
      push_exp(3'b010, 0); push_exp(3'b010, 0); push_exp(3'b000, 1); push_exp(3'b000, 0);
      for (int i = 0; i < 7; i++) push_exp(3'b000, 0);
      for (int i = 0; i < 11; i++) begin
         wait_tick();
         em = exp_mode_q.pop_front();
         ec = exp_chg_q.pop_front();
         vectors++;
         if (motor_mode !== em) begin miscompares++; $display("FAIL glitch_mode[%0d]: motor_mode=%b required %b", i, motor_mode, em); end
         vectors++;
         if (mode_changed !== ec) begin miscompares++; $display("FAIL glitch_chg[%0d]: mode_changed=%b required %b", i, mode_changed, ec); end
         if (i == 3) begin p0 = pulses; set_paddles(4'b1000); end
         if (i == 4) set_paddles(4'b0000);
         if (i == 7) set_paddles(4'b1100);
      end
      vectors++;
      if (pulses - p0 !== 0) begin miscompares++; $display("FAIL glitch_pulses: count=%0d required 0", pulses - p0); end
   endtask

   task automatic test_brake_ramp();
      logic [2:0] em;
      logic ec;
      set_paddles(4'b1000);
      push_exp(3'b000, 0); push_exp(3'b000, 0); push_exp(3'b001, 1); push_exp(3'b001, 0);
      push_exp(3'b001, 0); push_exp(3'b001, 0); push_exp(3'b000, 1); push_exp(3'b011, 1);
      push_exp(3'b100, 1); push_exp(3'b100, 0);
      for (int i = 0; i < 10; i++) begin
         wait_tick();
         em = exp_mode_q.pop_front();
         ec = exp_chg_q.pop_front();
         vectors++;
         if (motor_mode !== em) begin miscompares++; $display("FAIL brake_mode[%0d]: motor_mode=%b required %b", i, motor_mode, em); end
         vectors++;
         if (mode_changed !== ec) begin miscompares++; $display("FAIL brake_chg[%0d]: mode_changed=%b required %b", i, mode_changed, ec); end
         if (i == 3) set_paddles(4'b0110);
      end
   endtask

   task automatic test_reset_in_brake();
      int n;
      logic [2:0] em;
      logic ec;
      set_paddles(4'b1001);
      push_exp(3'b100, 0); push_exp(3'b100, 0); push_exp(3'b000, 1);
      for (int i = 0; i < 3; i++) begin
         wait_tick();
         em = exp_mode_q.pop_front();
         ec = exp_chg_q.pop_front();
         vectors++;
         if (motor_mode !== em) begin miscompares++; $display("FAIL rib_mode[%0d]: motor_mode=%b required %b", i, motor_mode, em); end
         vectors++;
         if (mode_changed !== ec) begin miscompares++; $display("FAIL rib_chg[%0d]: mode_changed=%b required %b", i, mode_changed, ec); end
      end
      // Land reset on the cycle where the BRAKE-exit tick is pending.
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (tick !== 1'b1 && n < 20);
      vectors++;
      if (n !== 4) begin miscompares++; $display("FAIL rib_tick_pending: gap=%0d required 4", n); end
      reset = 1'b1;
      #1;
      vectors++;
      if (tick !== 1'b0) begin miscompares++; $display("FAIL rib_tick_masked: tick=%b required 0", tick); end
      @(posedge clk);
      #1 reset = 1'b0;
      vectors++;
      if (motor_mode !== 3'b000) begin miscompares++; $display("FAIL rib_mode_rst: motor_mode=%b required 000", motor_mode); end
      vectors++;
      if (mode_changed !== 1'b0) begin miscompares++; $display("FAIL rib_chg_rst: mode_changed=%b required 0", mode_changed); end
      vectors++;
      if (tick !== 1'b0) begin miscompares++; $display("FAIL rib_tick_rst: tick=%b required 0", tick); end
      measure_gap(n);
      vectors++;
      if (n !== 4) begin miscompares++; $display("FAIL rib_first_tick: gap=%0d required 4", n); end
      vectors++;
      if (motor_mode !== 3'b000) begin miscompares++; $display("FAIL rib_first_tick_mode: motor_mode=%b required 000", motor_mode); end
      push_exp(3'b000, 0); push_exp(3'b001, 1); push_exp(3'b010, 1);
      for (int i = 0; i < 3; i++) begin
         wait_tick();
         em = exp_mode_q.pop_front();
         ec = exp_chg_q.pop_front();
         vectors++;
         if (motor_mode !== em) begin miscompares++; $display("FAIL rib_post_mode[%0d]: motor_mode=%b required %b", i, motor_mode, em); end
         vectors++;
         if (mode_changed !== ec) begin miscompares++; $display("FAIL rib_post_chg[%0d]: mode_changed=%b required %b", i, mode_changed, ec); end
      end
   endtask

   initial begin
      reset = 1'b1;
      set_paddles(4'b0000);
      test_reset();
      test_fwd();
      test_reverse();
      test_ramp_right();
      test_glitch();
      test_brake_ramp();
      test_reset_in_brake();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/motor_mode_sequencer.md
MOTOR_MODE_SEQUENCER -- requirements
Module: motor_mode_sequencer

Interface
REQ-001 Parameter CLK_DIV, default 20_000_000, clk cycles per tick (5 Hz at 100 MHz); legal range 2..2^26.
REQ-002 Parameter STABLE_TICKS, default 2, consecutive equal tick samples needed to accept a request; legal range 1..15.
REQ-003 Port clk  in  1  single system clock; all logic on its rising edge.
REQ-004 Port reset  in  1  synchronous, active-high reset.
REQ-005 Ports left_fwd, left_rev, right_fwd, right_rev  in  1 each  raw paddle inputs, sampled only on tick.
REQ-006 Port motor_mode  out  3  current commanded mode, registered.
REQ-007 Port mode_changed  out  1  one-cycle pulse, coincident with every motor_mode update.
REQ-008 Port tick  out  1  one-cycle tick strobe, for downstream blocks.

Function
REQ-009 Tick: counter 0..CLK_DIV-1, +1 per clk; tick=1 for exactly the cycle the counter equals CLK_DIV-1, counter wraps to 0; period is exactly CLK_DIV cycles.
REQ-010 Decode {left_fwd,left_rev,right_fwd,right_rev}: 0000 STOP, 1000/0001 R_1X, 1001 R_2X, 0010/0100 L_1X, 0110 L_2X, 1010 FWD, 0101 REV, all others STOP.
REQ-011 Encodings: STOP 000, R_1X 001, R_2X 010, L_1X 011, L_2X 100, FWD 101, REV 110; 111 is never driven.
REQ-012 Debounce, on each tick: decoded == candidate -> stable count +1, saturating at STABLE_TICKS; else candidate <= decoded and count <= 1.
REQ-013 When count equals STABLE_TICKS after a tick update, target <= candidate; target is otherwise held.
REQ-014 The sequencer steps only on ticks, using the target registered at an earlier tick; motor_mode changes at most once per tick.
REQ-015 Latency: inputs stable before tick t0 -> target valid after tick t0+STABLE_TICKS-1 -> first motor_mode step at tick t0+STABLE_TICKS.
REQ-016 FSM states RUN and BRAKE; reset state is RUN.
REQ-017 RUN, target opposite to motor_mode (FWD<->REV; any R_* <-> any L_*): motor_mode <= STOP, go to BRAKE.
REQ-018 BRAKE: hold STOP for one tick; at the next tick go to RUN and apply the REQ-019/020 rules to the then-current target.
REQ-019 Ramp: target R_2X/L_2X while motor_mode is not the same-side 1X or 2X -> motor_mode <= same-side 1X; 2X is applied at the following tick if the target is unchanged.
REQ-020 All other RUN cases: motor_mode <= target; target == motor_mode -> no update and no mode_changed.
REQ-021 mode_changed=1 only in the cycle a tick writes a value different from the previous motor_mode.
REQ-022 A target change during BRAKE or a ramp step takes effect at the next step; it never causes two steps in one tick.

Reset
REQ-023 reset=1 forces: tick counter 0, tick 0, motor_mode STOP, mode_changed 0, state RUN, target STOP, candidate STOP, stable count 0.
REQ-024 reset overrides a coincident tick; the first tick after reset release occurs exactly CLK_DIV cycles after release.

Structure
REQ-025 A shared package motor_pkg holds the mode encodings, the input bit-order constant, and the opposite-side and same-side-1X helper functions.
REQ-026 The tick divider is the sub-module clk_enable_div (parameter DIV, ports clk, reset, tick); the decode, debounce and FSM logic stay in this module.

Verification (CLK_DIV=4, STABLE_TICKS=2)
REQ-027 Reset, then 1010 held -> motor_mode 000 -> 101 at the 2nd tick after application; one mode_changed pulse; tick period 4 cycles.
REQ-028 From FWD, apply 0101 -> after acceptance: 000 at one tick, 110 at the next tick; 2 pulses total.
REQ-029 From STOP, apply 1001 -> 001 at the first step tick, 010 at the next tick.
REQ-030 From STOP, 1000 for one tick only, then 0000 -> motor_mode stays 000, no pulse; 1100 held -> stays 000.
REQ-031 From R_1X, apply 0110 -> 000, then 011, then 100 on consecutive ticks.
REQ-032 reset pulsed while in BRAKE -> next cycle all outputs at REQ-023 values; first tick exactly 4 cycles after release.
